coupling_weight_ctrl: RTL

// AXI4-Lite slave that initiates writes into, and readbacks from, the per-cell weight registers of the NxN coupled-cell array.

---
 rtl/coupling_weight_ctrl_pkg.sv | 37 +++
 rtl/coupling_weight_ctrl_if.sv | 35 +++
 rtl/coupling_weight_ctrl_addr_decode.sv | 41 ++++
 rtl/coupling_weight_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/coupling_weight_ctrl_pkg.sv
// Shared definitions for the coupled-cell weight controller: FSM states,
// AXI response codes and the address-field layout as a function of N.
package coupling_weight_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STROBE,
    ST_WR_RESP,
    ST_RD_SEL,
    ST_RD_CAP,
    ST_RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the row / col fields inside the word address.
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Word-address bit where the col field starts (bit 0 is the vh select).
  function automatic int col_lsb(input int n);
    return (n > 0) ? 1 : 1;
  endfunction

  // Word-address bit where the row field starts.
  function automatic int row_lsb(input int n);
    return 1 + field_w(n);
  endfunction

  // Number of word-address bits that carry meaning; anything above is an error.
  function automatic int used_bits(input int n);
    return 1 + 2 * field_w(n);
  endfunction

endpackage

// File: rtl/coupling_weight_ctrl_if.sv
// AXI4-Lite channel bundle between the host interconnect and the weight controller.
interface coupling_weight_ctrl_if;

  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

endinterface

// File: rtl/coupling_weight_ctrl_addr_decode.sv
// Byte address -> (row, col, vh) decode with a one-hot cell select and a
// decode-error flag. Used for both the write and the read address paths.
module weight_addr_decode
  import coupling_weight_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = field_w(N)
) (
  input  logic [31:0]    addr,
  output logic [CW-1:0]  row,
  output logic [CW-1:0]  col,
  output logic           vh,
  output logic [N*N-1:0] onehot,
  output logic           err
);

  localparam int USED    = used_bits(N);
  localparam int COL_LSB = col_lsb(N);
  localparam int ROW_LSB = row_lsb(N);
  localparam logic [N*N-1:0] ONE = {{(N*N-1){1'b0}}, 1'b1};

  logic [29:0] word;
  logic        unused_byte_lane;

  // Byte lane bits carry no meaning for 32-bit weight registers.
  assign unused_byte_lane = ^addr[1:0];
  assign word = addr[31:2];
  assign vh   = word[0];
  assign col  = word[COL_LSB +: CW];
  assign row  = word[ROW_LSB +: CW];

  // Flag out-of-range fields and stray high address bits; no cell is selected on error.
  always_comb begin
    err    = ((word >> USED) != '0) || (int'(row) >= N) || (int'(col) >= N);
    onehot = '0;
    if (!err) begin
      onehot = ONE << (int'(row) * N + int'(col));
    end
  end

endmodule

// File: rtl/coupling_weight_ctrl.sv
// AXI4-Lite slave that writes and reads back per-cell weight registers of the
// NxN coupled-cell array over a shared cell bus. One transaction in flight.
module coupling_weight_ctrl
  import coupling_weight_ctrl_pkg::*;
#(
  parameter int N           = 8,
  parameter int NUM_WEIGHTS = 15
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  coupling_weight_ctrl_if.slave s,
  output logic                 cell_wready,
  output logic [N*N-1:0]       cell_match,
  output logic                 cell_vh,
  output logic [31:0]          cell_wdata,
  input  logic [N*N*32-1:0]    cell_rdata
);

  localparam int WW = $clog2(NUM_WEIGHTS);
  localparam int CW = field_w(N);
  localparam logic [31:0] MAX_W = 32'(NUM_WEIGHTS - 1);

  state_t state, state_nxt;

  logic           aw_held, w_held;
  logic [31:0]    awaddr_q, wdata_q, araddr_q;
  logic           aw_hs, w_hs, ar_hs;
  logic           aw_vh, ar_vh, aw_err, ar_err, wr_err;
  logic [N*N-1:0] aw_onehot, ar_onehot;
  logic [CW-1:0]  unused_aw_row, unused_aw_col, unused_ar_row, unused_ar_col;
  logic           unused_cell_rdata;
  logic [WW-1:0]  rd_mux;
  logic [31:0]    rdata_q;
  logic [1:0]     rresp_q;
  logic           bvalid, rvalid;
  logic [1:0]     bresp;

  // Only the low WW bits of each cell's readback are meaningful.
  assign unused_cell_rdata = ^cell_rdata;

  weight_addr_decode #(.N(N)) u_aw_dec (
    .addr   (awaddr_q),
    .row    (unused_aw_row),
    .col    (unused_aw_col),
    .vh     (aw_vh),
    .onehot (aw_onehot),
    .err    (aw_err)
  );

  weight_addr_decode #(.N(N)) u_ar_dec (
    .addr   (araddr_q),
    .row    (unused_ar_row),
    .col    (unused_ar_col),
    .vh     (ar_vh),
    .onehot (ar_onehot),
    .err    (ar_err)
  );

  // Write has priority: a read is only offered when no write is held or being presented.
  assign s.s_awready = (state == ST_IDLE) && !aw_held && !axi_rst;
  assign s.s_wready  = (state == ST_IDLE) && !w_held && !axi_rst;
  assign s.s_arready = (state == ST_IDLE) && !aw_held && !w_held &&
                       !s.s_awvalid && !s.s_wvalid && !axi_rst;

  assign aw_hs  = s.s_awvalid && s.s_awready;
  assign w_hs   = s.s_wvalid && s.s_wready;
  assign ar_hs  = s.s_arvalid && s.s_arready;
  assign wr_err = aw_err || (wdata_q > MAX_W);

  assign s.s_bvalid = bvalid;
  assign s.s_bresp  = bresp;
  assign s.s_rvalid = rvalid;
  assign s.s_rdata  = rdata_q;
  assign s.s_rresp  = rresp_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Track which write halves have been accepted; released once the response is taken.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (state == ST_WR_RESP && s.s_bready) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  // Capture address/data payloads on their handshakes.
  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= s.s_awaddr;
    if (w_hs)  wdata_q  <= s.s_wdata;
    if (ar_hs) araddr_q <= s.s_araddr;
  end

  // Select the addressed cell's weight bits from the flattened readback bus.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N * N; k++) begin
      if (ar_onehot[k]) begin
        rd_mux = rd_mux | cell_rdata[k*32 +: WW];
      end
    end
  end

  // Register the read response once the cell mux has had a full cycle to settle.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (state == ST_RD_CAP) begin
      rdata_q <= ar_err ? 32'h0 : {{(32-WW){1'b0}}, rd_mux};
      rresp_q <= ar_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Next-state and cell-bus / response outputs.
  always_comb begin
    state_nxt   = state;
    bvalid      = 1'b0;
    bresp       = RESP_OKAY;
    rvalid      = 1'b0;
    cell_wready = 1'b0;
    cell_match  = '0;
    cell_vh     = 1'b0;
    cell_wdata  = '0;
    case (state)
      ST_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          state_nxt = ST_WR_STROBE;
        end else if (ar_hs) begin
          state_nxt = ST_RD_SEL;
        end
      end
      ST_WR_STROBE: begin
        if (!wr_err) begin
          cell_wready = 1'b1;
          cell_match  = aw_onehot;
          cell_vh     = aw_vh;
          cell_wdata  = wdata_q;
        end
        state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        bvalid = 1'b1;
        bresp  = wr_err ? RESP_SLVERR : RESP_OKAY;
        if (s.s_bready) state_nxt = ST_IDLE;
      end
      ST_RD_SEL: begin
        cell_match = ar_onehot;
        cell_vh    = ar_vh;
        state_nxt  = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        // Keep the vh select steady so the captured readback is the settled one.
        cell_vh   = ar_vh;
        state_nxt = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        rvalid = 1'b1;
        if (s.s_rready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
